// File: rtl/aes_tx_serializer.sv
// Byte serializer between the cipher core and the SPI slave transmit register.
// Define AES_TX_CRC_EN to append a CRC-8 (poly 0x07) trailer byte to each frame.
module aes_tx_serializer #(
  parameter int NBYTES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8*NBYTES-1:0] block_in,
  input  logic                block_valid,
  output logic                block_ready,
  input  logic                cs,
  input  logic                byte_done,
  output logic [7:0]          byte_out,
  output logic                busy,
  output logic                frame_done,
  output logic                abort
);

  localparam int BW = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);

`ifdef AES_TX_CRC_EN
  typedef enum logic [1:0] {IDLE, SEND, CRC} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

  state_t          state, state_n;
  logic [BW-1:0]   shift_q, shift_n;
  logic [CW-1:0]   count_q, count_n;
  logic            frame_done_n, abort_n;
  logic            last_byte;

  // The counter is one bit wider than needed for NBYTES-1 so it can reach NBYTES.
  assign last_byte = (count_q == CW'(NBYTES - 1));

`ifdef AES_TX_CRC_EN
  logic [7:0] crc_q, crc_n;

  function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
`ifdef AES_TX_CRC_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      state      <= state_n;
      shift_q    <= shift_n;
      count_q    <= count_n;
      frame_done <= frame_done_n;
      abort      <= abort_n;
`ifdef AES_TX_CRC_EN
      crc_q      <= crc_n;
`endif
    end
  end

  // A cs deselect wins over a coincident byte_done and discards the block.
  always_comb begin
    state_n      = state;
    shift_n      = shift_q;
    count_n      = count_q;
    frame_done_n = 1'b0;
    abort_n      = 1'b0;
`ifdef AES_TX_CRC_EN
    crc_n        = crc_q;
`endif
    case (state)
      IDLE: begin
        if (block_valid) begin
          shift_n = block_in;
          count_n = '0;
`ifdef AES_TX_CRC_EN
          crc_n   = 8'h00;
`endif
          state_n = SEND;
        end
      end
      SEND: begin
        if (cs) begin
          state_n = IDLE;
          abort_n = 1'b1;
          shift_n = '0;
          count_n = '0;
        end else if (byte_done) begin
          shift_n = shift_q << 8;
          count_n = count_q + 1'b1;
`ifdef AES_TX_CRC_EN
          crc_n   = crc8_fold(crc_q, shift_q[BW-1 -: 8]);
          if (last_byte) state_n = CRC;
`else
          if (last_byte) begin
            state_n      = IDLE;
            frame_done_n = 1'b1;
          end
`endif
        end
      end
`ifdef AES_TX_CRC_EN
      CRC: begin
        if (cs) begin
          state_n = IDLE;
          abort_n = 1'b1;
          shift_n = '0;
          count_n = '0;
        end else if (byte_done) begin
          state_n      = IDLE;
          frame_done_n = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    block_ready = (state == IDLE);
    busy        = (state != IDLE);
    byte_out    = 8'h00;
    case (state)
      SEND:    byte_out = shift_q[BW-1 -: 8];
`ifdef AES_TX_CRC_EN
      CRC:     byte_out = crc_q;
`endif
      default: byte_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_aes_tx_serializer.sv
// Self-checking bench for aes_tx_serializer (NBYTES=16 main instance, NBYTES=1 edge instance).
// Expected bytes and CRC come from a polynomial long-division reference model.
module tb_aes_tx_serializer;

  localparam int NB = 16;
  localparam int BW = 8 * NB;

  logic          clk;
  logic          reset;
  logic [BW-1:0] block_in;
  logic          block_valid;
  logic          block_ready;
  logic          cs;
  logic          byte_done;
  logic [7:0]    byte_out;
  logic          busy;
  logic          frame_done;
  logic          abort;

  logic [7:0]    b1_block_in;
  logic          b1_valid, b1_ready, b1_cs, b1_done, b1_busy, b1_fd, b1_abort;
  logic [7:0]    b1_out;

  int total = 0;
  int bad   = 0;

  aes_tx_serializer #(.NBYTES(NB)) dut (
    .clk(clk), .reset(reset), .block_in(block_in), .block_valid(block_valid),
    .block_ready(block_ready), .cs(cs), .byte_done(byte_done), .byte_out(byte_out),
    .busy(busy), .frame_done(frame_done), .abort(abort)
  );

  aes_tx_serializer #(.NBYTES(1)) dut1 (
    .clk(clk), .reset(reset), .block_in(b1_block_in), .block_valid(b1_valid),
    .block_ready(b1_ready), .cs(b1_cs), .byte_done(b1_done), .byte_out(b1_out),
    .busy(b1_busy), .frame_done(b1_fd), .abort(b1_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRC as remainder of data(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_model(input logic [255:0] data, input int nbytes);
    logic [263:0] m;
    m = {data, 8'h00};
    for (int i = 8 * nbytes + 7; i >= 8; i--) begin
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    end
    return m[7:0];
  endfunction

  function automatic logic [7:0] exp_byte(input logic [BW-1:0] blk, input int i);
    logic [BW-1:0] t;
    t = blk >> (8 * (NB - 1 - i));
    return t[7:0];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic done_v, input logic cs_v);
    byte_done = done_v;
    cs        = cs_v;
    @(negedge clk);
    byte_done = 1'b0;
  endtask

  task automatic accept_block(input logic [BW-1:0] blk);
    block_in    = blk;
    block_valid = 1'b1;
    @(negedge clk);
    block_valid = 1'b0;
    block_in    = {$urandom, $urandom, $urandom, $urandom};
    check_output("accept_busy", 32'(busy), 32'd1);
    check_output("accept_ready", 32'(block_ready), 32'd0);
    check_output("accept_byte0", 32'(byte_out), 32'(exp_byte(blk, 0)));
  endtask

  // Walks every data byte (and trailer) of blk, ending in the frame_done cycle.
  task automatic run_bytes(input logic [BW-1:0] blk, input int min_gap, input int max_gap);
    int gap;
    for (int i = 0; i < NB; i++) begin
      check_output($sformatf("byte%0d", i), 32'(byte_out), 32'(exp_byte(blk, i)));
      gap = $urandom_range(max_gap, min_gap);
      repeat (gap) @(negedge clk);
      if (i == NB - 1) check_output("no_early_done", 32'(frame_done), 32'd0);
      apply_stimulus(1'b1, 1'b0);
    end
`ifdef AES_TX_CRC_EN
    check_output("crc_byte", 32'(byte_out), 32'(crc_model(256'(blk), NB)));
    check_output("crc_no_done", 32'(frame_done), 32'd0);
    apply_stimulus(1'b1, 1'b0);
`endif
    check_output("fd_pulse", 32'(frame_done), 32'd1);
    check_output("fd_ready", 32'(block_ready), 32'd1);
    check_output("fd_busy", 32'(busy), 32'd0);
    check_output("fd_byte", 32'(byte_out), 32'd0);
    check_output("fd_abort", 32'(abort), 32'd0);
  endtask

  initial begin
    logic [BW-1:0] blk;
    logic [BW-1:0] blk2;
    logic [7:0]    b;

    reset = 1'b0; block_in = '0; block_valid = 1'b0; cs = 1'b0; byte_done = 1'b0;
    b1_block_in = 8'h00; b1_valid = 1'b0; b1_cs = 1'b0; b1_done = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_ready", 32'(block_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_byte", 32'(byte_out), 32'd0);
    check_output("rst_fd", 32'(frame_done), 32'd0);
    check_output("rst_abort", 32'(abort), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] directed frame, byte_done every 8 cycles");
    blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    accept_block(blk);
    run_bytes(blk, 7, 7);
    @(negedge clk);
    check_output("fd_one_cycle", 32'(frame_done), 32'd0);

    $display("[TB] all-zero-but-one block");
    blk = 128'h1;
    accept_block(blk);
    run_bytes(blk, 0, 2);
    @(negedge clk);

    $display("[TB] byte_done in IDLE is ignored");
    apply_stimulus(1'b1, 1'b0);
    check_output("idle_done_busy", 32'(busy), 32'd0);
    check_output("idle_done_fd", 32'(frame_done), 32'd0);

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      accept_block(blk);
      run_bytes(blk, 0, 3);
      @(negedge clk);
    end

    $display("[TB] abort on cs with coincident 5th byte_done");
    blk = {$urandom, $urandom, $urandom, $urandom};
    accept_block(blk);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0);
    check_output("pre_abort_byte", 32'(byte_out), 32'(exp_byte(blk, 4)));
    apply_stimulus(1'b1, 1'b1);
    check_output("abort_pulse", 32'(abort), 32'd1);
    check_output("abort_no_fd", 32'(frame_done), 32'd0);
    check_output("abort_byte", 32'(byte_out), 32'd0);
    check_output("abort_ready", 32'(block_ready), 32'd1);
    cs = 1'b0;
    @(negedge clk);
    check_output("abort_one_cycle", 32'(abort), 32'd0);

    $display("[TB] block_valid held through a frame");
    blk  = {$urandom, $urandom, $urandom, $urandom};
    blk2 = {$urandom, $urandom, $urandom, $urandom};
    block_in = blk;
    block_valid = 1'b1;
    @(negedge clk);
    block_in = blk2;
    run_bytes(blk, 0, 1);
    @(negedge clk);
    block_valid = 1'b0;
    check_output("held_second_busy", 32'(busy), 32'd1);
    check_output("held_second_byte0", 32'(byte_out), 32'(exp_byte(blk2, 0)));
    run_bytes(blk2, 0, 1);
    @(negedge clk);

    $display("[TB] asynchronous reset mid-frame");
    blk = {$urandom, $urandom, $urandom, $urandom};
    accept_block(blk);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_output("async_rst_busy", 32'(busy), 32'd0);
    check_output("async_rst_byte", 32'(byte_out), 32'd0);
    check_output("async_rst_ready", 32'(block_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    blk = {$urandom, $urandom, $urandom, $urandom};
    accept_block(blk);
    run_bytes(blk, 0, 2);
    @(negedge clk);

    $display("[TB] single-byte instance");
    for (int f = 0; f < 3; f++) begin
      b = 8'($urandom);
      b1_block_in = b;
      b1_valid = 1'b1;
      @(negedge clk);
      b1_valid = 1'b0;
      check_output("b1_byte", 32'(b1_out), 32'(b));
      check_output("b1_busy", 32'(b1_busy), 32'd1);
      b1_done = 1'b1;
      @(negedge clk);
      b1_done = 1'b0;
`ifdef AES_TX_CRC_EN
      check_output("b1_crc", 32'(b1_out), 32'(crc_model(256'(b), 1)));
      b1_done = 1'b1;
      @(negedge clk);
      b1_done = 1'b0;
`endif
      check_output("b1_fd", 32'(b1_fd), 32'd1);
      check_output("b1_ready", 32'(b1_ready), 32'd1);
      check_output("b1_out_idle", 32'(b1_out), 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
